seg_txt_serializer: RTL

SEG_TXT_SERIALIZER -- requirements
Module: seg_txt_serializer

---
 rtl/seg_txt_serializer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/seg_txt_serializer.sv
// Segment-text serializer: shifts a 64-bit digit frame out LSB first on sout/sclk, then strobes sen.
// Optional build macro SEG_P2S_AUTO_REFRESH_EN: frames run back-to-back and start is ignored.
module seg_txt_serializer #(
    parameter int unsigned DIV = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] SEG_TXT,
    output logic        sout,
    output logic        sclk,
    output logic        sen,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LATCH,
        DONE
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(DIV - 1);
    localparam logic [5:0]  BIT_LAST = 6'd63;

    state_t      state_q, state_d;
    logic [63:0] shreg_q, shreg_d;
    logic [5:0]  bit_q, bit_d;
    logic [15:0] div_q, div_d;
    logic        sout_d, sclk_d, sen_d, busy_d, done_d;
    logic        go;
    logic        div_end;

`ifdef SEG_P2S_AUTO_REFRESH_EN
    assign go = 1'b1;
`else
    assign go = start;
`endif

    assign div_end = (div_q == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            bit_q   <= '0;
            div_q   <= '0;
            sout    <= 1'b0;
            sclk    <= 1'b0;
            sen     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            sout    <= sout_d;
            sclk    <= sclk_d;
            sen     <= sen_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // shreg holds only the bits not yet presented on sout, so its LSB is always the next bit.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        div_d   = div_q;
        sout_d  = sout;
        sclk_d  = sclk;
        sen_d   = sen;
        busy_d  = busy;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                sclk_d = 1'b0;
                sen_d  = 1'b0;
                busy_d = 1'b0;
                if (go) begin
                    shreg_d = {1'b0, SEG_TXT[63:1]};
                    sout_d  = SEG_TXT[0];
                    bit_d   = '0;
                    div_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (div_end) begin
                    div_d   = '0;
                    sclk_d  = 1'b1;
                    state_d = SHIFT_HI;
                end else begin
                    div_d = div_q + 16'd1;
                end
            end
            SHIFT_HI: begin
                if (div_end) begin
                    div_d  = '0;
                    sclk_d = 1'b0;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        sen_d   = 1'b1;
                        state_d = LATCH;
                    end else begin
                        sout_d  = shreg_q[0];
                        shreg_d = {1'b0, shreg_q[63:1]};
                        bit_d   = bit_q + 6'd1;
                        state_d = SHIFT_LO;
                    end
                end else begin
                    div_d = div_q + 16'd1;
                end
            end
            LATCH: begin
                sclk_d = 1'b0;
                if (div_end) begin
                    div_d   = '0;
                    sen_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    div_d = div_q + 16'd1;
                end
            end
            DONE: begin
                div_d   = '0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
